// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one fifo write port between NUM_REQ valid/ready
// requesters, with optional burst locking delimited by req_last.
module fifo_write_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]         req_data,
  input  logic [NUM_REQ-1:0]                req_last,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              fifo_write_en,
  output logic [DATA_W-1:0]                 fifo_write_data,
  input  logic                              fifo_full,
  output logic                              locked,
  output logic [$clog2(NUM_REQ)-1:0]        owner
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic               r_locked;

  state_t             w_state_nxt;
  logic [PTR_W-1:0]   w_rr_ptr_nxt;
  logic [PTR_W-1:0]   w_owner_nxt;
  logic [CNT_W-1:0]   w_beat_cnt_nxt;
  logic               w_locked_nxt;

  logic               w_grant_vld;
  logic [PTR_W-1:0]   w_grant;
  logic [PTR_W-1:0]   w_idx;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_accept;
  logic               w_burst_end;
  logic [PTR_W-1:0]   w_grant_inc;

  // Grant: owner while locked, else first valid requester from rr_ptr upward.
  // Scanning offsets high-to-low lets the lowest offset win the final write.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_idx       = '0;
    if (r_state == LOCKED) begin
      w_grant_vld = 1'b1;
      w_grant     = r_owner;
    end else begin
      for (int unsigned k = NUM_REQ; k > 0; k--) begin
        if ((32'(r_rr_ptr) + k - 1) >= NUM_REQ) begin
          w_idx = PTR_W'(32'(r_rr_ptr) + k - 1 - NUM_REQ);
        end else begin
          w_idx = PTR_W'(32'(r_rr_ptr) + k - 1);
        end
        if (req_valid[w_idx]) begin
          w_grant_vld = 1'b1;
          w_grant     = w_idx;
        end
      end
    end
  end

  // Payload mux for the granted requester.
  always_comb begin
    w_sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant == PTR_W'(i)) begin
        w_sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_accept    = w_grant_vld & req_valid[w_grant] & ~fifo_full & ~reset;
  assign w_burst_end = req_last[w_grant] | (r_beat_cnt == LAST_CNT);
  assign w_grant_inc = (w_grant == LAST_REQ) ? '0 : w_grant + PTR_W'(1);

  // Next-state and write-port outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_owner_nxt     = r_owner;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_locked_nxt    = r_locked;
    req_ready       = '0;
    fifo_write_en   = 1'b0;
    fifo_write_data = '0;
    if (w_accept) begin
      req_ready       = NUM_REQ'(1) << w_grant;
      fifo_write_en   = 1'b1;
      fifo_write_data = w_sel_data;
      w_owner_nxt     = w_grant;
      if (w_burst_end) begin
        w_state_nxt    = IDLE;
        w_locked_nxt   = 1'b0;
        w_beat_cnt_nxt = '0;
        w_rr_ptr_nxt   = w_grant_inc;
      end else begin
        w_state_nxt    = LOCKED;
        w_locked_nxt   = 1'b1;
        w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_locked   <= w_locked_nxt;
    end
  end

  assign locked = r_locked;
  assign owner  = r_owner;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a burst-level reference model.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic              clk;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_last;
  logic [N-1:0]      req_ready;
  logic              fifo_write_en;
  logic [DW-1:0]     fifo_write_data;
  logic              fifo_full;
  logic              locked;
  logic [1:0]        owner;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .fifo_write_en   (fifo_write_en),
    .fifo_write_data (fifo_write_data),
    .fifo_full       (fifo_full),
    .locked          (locked),
    .owner           (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_wr     = 0;

  // Requester-side beats: a beat's data stays put until it is accepted.
  logic [N-1:0]  pend;
  logic [N-1:0]  lst;
  logic [DW-1:0] dat [N];

  // Reference model: who holds the port, beats sent in this burst, who is next.
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_beats;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int exp_grant();
    if (m_locked) return m_owner;
    for (int k = 0; k < N; k++) begin
      if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    m_beats  = 0;
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
    int g;
    bit acc;
    logic [N-1:0]  e_rdy;
    logic [DW-1:0] e_dat;
    pend = v;
    lst  = l;
    req_valid = v;
    req_last  = l;
    fifo_full = f;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = dat[i];
    @(negedge clk);
    g     = exp_grant();
    acc   = (g >= 0) && pend[g] && !f;
    e_rdy = acc ? (N'(1) << g) : '0;
    e_dat = acc ? dat[g] : '0;
    chk("ready",  64'(req_ready),       64'(e_rdy));
    chk("wen",    64'(fifo_write_en),   64'(acc));
    chk("wdata",  64'(fifo_write_data), 64'(e_dat));
    chk("locked", 64'(locked),          64'(m_locked));
    chk("owner",  64'(owner),           64'(m_owner));
    if (fifo_write_en) n_wr++;
    if (acc) begin
      m_beats++;
      m_owner = g;
      if (lst[g] || m_beats == MB) begin
        m_locked = 1'b0;
        m_beats  = 0;
        m_ptr    = (g + 1) % N;
      end else begin
        m_locked = 1'b1;
      end
      pend[g] = 1'b0;
      dat[g]  = $urandom;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) dat[i] = $urandom;
    pend      = '1;
    lst       = '1;
    reset     = 1'b1;
    req_valid = '1;
    req_last  = '1;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = dat[i];
    model_reset();

    // Reset state with every requester valid.
    @(posedge clk);
    #1;
    chk("rst_ready",  64'(req_ready),     64'(0));
    chk("rst_wen",    64'(fifo_write_en), 64'(0));
    chk("rst_locked", 64'(locked),        64'(0));
    chk("rst_owner",  64'(owner),         64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Round robin with single-beat groups: expect grants 0,1,2,3,0,1,2,3.
    for (int c = 0; c < 8; c++) begin
      step(4'b1111, 4'b1111, 1'b0);
      chk("rr_owner", 64'(owner), 64'(c % N));
    end

    // Burst lock: req1 three beats while req0/req2 wait, then req2.
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0111, 4'b0000, 1'b0);
    step(4'b0111, 4'b0000, 1'b0);
    chk("burst_locked", 64'(locked), 64'(1));
    step(4'b0111, 4'b0010, 1'b0);
    step(4'b0101, 4'b0101, 1'b0);
    chk("burst_next", 64'(owner), 64'(2));

    // Forced release: req3 never raises last, lock drops after MB beats.
    for (int b = 0; b < MB; b++) step(4'b1001, 4'b0000, 1'b0);
    chk("force_unlock", 64'(locked), 64'(0));
    step(4'b1001, 4'b0001, 1'b0);
    chk("force_req0", 64'(owner), 64'(0));
    step(4'b1000, 4'b0000, 1'b0);
    step(4'b1000, 4'b1000, 1'b0);

    // Full back-pressure mid-burst of req2.
    n_wr = 0;
    step(4'b0100, 4'b0000, 1'b0);
    step(4'b0100, 4'b0000, 1'b0);
    for (int c = 0; c < 3; c++) step(4'b0100, 4'b0000, 1'b1);
    chk("full_held", 64'(locked), 64'(1));
    step(4'b0100, 4'b0000, 1'b0);
    step(4'b0100, 4'b0000, 1'b0);
    chk("full_writes", 64'(n_wr), 64'(4));
    chk("full_unlock", 64'(locked), 64'(0));

    // Owner bubble: req0 pauses mid-burst, req1 must wait.
    step(4'b0011, 4'b0000, 1'b0);
    step(4'b0010, 4'b0000, 1'b0);
    step(4'b0010, 4'b0000, 1'b0);
    chk("bubble_locked", 64'(locked), 64'(1));
    step(4'b0011, 4'b0000, 1'b0);
    step(4'b0011, 4'b0001, 1'b0);
    step(4'b0010, 4'b0010, 1'b0);
    chk("bubble_req1", 64'(owner), 64'(1));

    // Randomized traffic; pending beats persist until accepted.
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] v;
      logic [N-1:0] l;
      v = pend;
      l = lst;
      for (int i = 0; i < N; i++) begin
        if (!v[i]) begin
          v[i] = ($urandom_range(2) != 0);
          l[i] = ($urandom_range(2) == 0);
        end
      end
      step(v, l, ($urandom_range(4) == 0));
    end

    // Reset mid-burst drops the lock immediately.
    step(4'b0010, 4'b0000, 1'b0);
    step(4'b0010, 4'b0000, 1'b0);
    chk("pre_rst_locked", 64'(locked), 64'(1));
    req_valid = '1;
    req_last  = '0;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready",  64'(req_ready),     64'(0));
    chk("mid_rst_wen",    64'(fifo_write_en), 64'(0));
    chk("mid_rst_locked", 64'(locked),        64'(0));
    chk("mid_rst_owner",  64'(owner),         64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    step(4'b1111, 4'b1111, 1'b0);
    chk("post_rst_owner", 64'(owner), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
